// File: rtl/sc_pkg.sv
// Shared definitions for the stochastic-computing dot-product blocks.
// Holds LFSR geometry, product-mode constants, FSM encodings and helpers.
// No logic of its own; imported by every sc_* module.
package sc_pkg;

    // 16-bit Fibonacci LFSR, polynomial taps 16,15,13,4 (bits 15,14,12,3)
    localparam int          LFSR_W    = 16;
    localparam logic [15:0] LFSR_TAPS = 16'hD008;

    // Product modes: AND for unipolar streams, XNOR for bipolar streams
    localparam int SC_UNIPOLAR = 0;
    localparam int SC_BIPOLAR  = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sc_state_e;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >>> 1;
        end
        return r;
    endfunction

    // LFSR bit feeding select bit i: spaced three apart so no two are adjacent
    function automatic int sel_tap(input int i);
        return 3 * i + 1;
    endfunction

endpackage

// File: rtl/sc_lfsr.sv
// Fibonacci LFSR with enable; exposes the full state register.
// Latency: state updates on the edge where en is high.
// No backpressure: en alone decides whether the sequence advances.
module sc_lfsr
    import sc_pkg::*;
#(
    parameter int                WIDTH = 16,
    parameter logic [WIDTH-1:0]  SEED  = 16'hACE1,
    parameter logic [WIDTH-1:0]  TAPS  = 16'hD008
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] state
);

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;
    logic             fb;

    // Next state: shift left, feedback is the parity of the tapped bits
    always_comb begin
        fb      = ^(state_q & TAPS);
        state_d = state_q;
        if (en) begin
            state_d = {state_q[WIDTH-2:0], fb};
        end
    end

    // State register, reloads the seed on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/sc_dot_product_array.sv
// Multi-channel stochastic dot product (mux-selected products) with windowed ones counters.
// Latency: result_bits 1 cycle after an accepted sample; count_valid the cycle after DONE.
// No backpressure out; in_valid low stalls the window and freezes the select LFSR.
module sc_dot_product_array
    import sc_pkg::*;
#(
    parameter int          LENGTH       = 4,
    parameter int          SELECT_WIDTH = 2,
    parameter int          NUM_OUT      = 2,
    parameter int          WINDOW_BITS  = 8,
    parameter int          BIPOLAR      = 0,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic                                 in_valid,
    input  logic [LENGTH-1:0]                    data,
    input  logic [NUM_OUT*LENGTH-1:0]            weights,
    input  logic                                 sel_ext,
    input  logic [SELECT_WIDTH-1:0]              sel,
    output logic                                 busy,
    output logic [NUM_OUT-1:0]                   result_bits,
    output logic                                 bit_valid,
    output logic [NUM_OUT*(WINDOW_BITS+1)-1:0]   count,
    output logic                                 count_valid
);

    // Wide enough to hold a full window of ones without wrapping
    localparam int               CNT_W = clog2((1 << WINDOW_BITS) + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'((1 << WINDOW_BITS) - 1);

    sc_state_e                  state_q, state_d;
    logic [CNT_W-1:0]           samp_q, samp_d;
    logic [NUM_OUT-1:0]         result_bits_q, result_bits_d;
    logic                       bit_valid_q, bit_valid_d;
    logic [NUM_OUT*CNT_W-1:0]   count_q, count_d;
    logic                       count_valid_q, count_valid_d;

    logic                       accept;
    logic                       clr;
    logic [LFSR_W-1:0]          lfsr;
    logic                       lfsr_unused;
    logic [SELECT_WIDTH-1:0]    sel_int;
    logic [SELECT_WIDTH-1:0]    sel_eff;
    logic [NUM_OUT-1:0]         prod_bit;
    logic [NUM_OUT*CNT_W-1:0]   cnt_all;

    assign accept = (state_q == ST_RUN) && in_valid;

    sc_lfsr #(
        .WIDTH (LFSR_W),
        .SEED  (LFSR_SEED),
        .TAPS  (LFSR_TAPS)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .en    (accept),
        .state (lfsr)
    );

    // Only a few LFSR bits feed the select; the rest exist for sequence length
    assign lfsr_unused = ^lfsr;

    for (genvar i = 0; i < SELECT_WIDTH; i++) begin : g_sel
        assign sel_int[i] = lfsr[sel_tap(i)];
    end

    assign sel_eff = sel_ext ? sel : sel_int;

    for (genvar c = 0; c < NUM_OUT; c++) begin : g_ch
        logic [LENGTH-1:0] w;
        logic [LENGTH-1:0] prod;
        logic [CNT_W-1:0]  cnt_q, cnt_d;

        assign w           = weights[c*LENGTH +: LENGTH];
        assign prod        = (BIPOLAR == SC_BIPOLAR) ? ~(data ^ w) : (data & w);
        assign prod_bit[c] = prod[sel_eff];

        // Ones counter: cleared when a window starts, bumped per accepted sample
        always_comb begin
            cnt_d = cnt_q;
            if (clr) begin
                cnt_d = '0;
            end else if (accept) begin
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, prod_bit[c]};
            end
        end

        // Ones counter register
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign cnt_all[c*CNT_W +: CNT_W] = cnt_q;
    end

    // Window FSM plus sample counter and output register next-state
    always_comb begin
        state_d       = state_q;
        samp_d        = samp_q;
        result_bits_d = result_bits_q;
        bit_valid_d   = 1'b0;
        count_d       = count_q;
        count_valid_d = 1'b0;
        clr           = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    samp_d  = '0;
                    clr     = 1'b1;
                end
            end
            ST_RUN: begin
                if (in_valid) begin
                    result_bits_d = prod_bit;
                    bit_valid_d   = 1'b1;
                    samp_d        = samp_q + 1'b1;
                    if (samp_q == LAST) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                // Counters are final here; publish them on the way back to IDLE
                count_d       = cnt_all;
                count_valid_d = 1'b1;
                state_d       = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            samp_q        <= '0;
            result_bits_q <= '0;
            bit_valid_q   <= 1'b0;
            count_q       <= '0;
            count_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            samp_q        <= samp_d;
            result_bits_q <= result_bits_d;
            bit_valid_q   <= bit_valid_d;
            count_q       <= count_d;
            count_valid_q <= count_valid_d;
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign result_bits = result_bits_q;
    assign bit_valid   = bit_valid_q;
    assign count       = count_q;
    assign count_valid = count_valid_q;

endmodule

// File: tb/tb_sc_dot_product_array.sv
// Scoreboard bench: a unipolar and a bipolar instance share one stimulus stream.
// Driver computes expected bits/counts from a plain model and queues them.
// Negedge monitor pops and compares whenever bit_valid or count_valid is seen.
module tb_sc_dot_product_array;

    localparam int          L    = 4;
    localparam int          SW   = 2;
    localparam int          NO   = 2;
    localparam int          WB   = 4;
    localparam int          CW   = WB + 1;
    localparam int          N    = 1 << WB;
    localparam logic [15:0] SEED = 16'hACE1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic in_valid = 1'b0;
    logic sel_ext = 1'b0;
    logic [L-1:0]    data = '0;
    logic [NO*L-1:0] weights = '0;
    logic [SW-1:0]   sel = '0;

    logic            busy [2];
    logic [NO-1:0]   rb   [2];
    logic            bv   [2];
    logic [NO*CW-1:0] cnt [2];
    logic            cv   [2];

    always #5 clk = ~clk;

    sc_dot_product_array #(.LENGTH(L), .SELECT_WIDTH(SW), .NUM_OUT(NO), .WINDOW_BITS(WB),
                           .BIPOLAR(0), .LFSR_SEED(SEED)) dut_uni (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .data(data),
        .weights(weights), .sel_ext(sel_ext), .sel(sel), .busy(busy[0]),
        .result_bits(rb[0]), .bit_valid(bv[0]), .count(cnt[0]), .count_valid(cv[0]));

    sc_dot_product_array #(.LENGTH(L), .SELECT_WIDTH(SW), .NUM_OUT(NO), .WINDOW_BITS(WB),
                           .BIPOLAR(1), .LFSR_SEED(SEED)) dut_bip (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .data(data),
        .weights(weights), .sel_ext(sel_ext), .sel(sel), .busy(busy[1]),
        .result_bits(rb[1]), .bit_valid(bv[1]), .count(cnt[1]), .count_valid(cv[1]));

    typedef struct {
        int               cyc;
        logic [NO*CW-1:0] cnt;
    } cnt_exp_t;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit mon_en = 1'b0;
    logic [15:0] lfsr_m = SEED;

    logic [NO-1:0] qb [2][$];
    cnt_exp_t      qc [2][$];

    // Window stimulus tables
    logic [L-1:0]    sd   [N];
    logic [NO*L-1:0] swt  [N];
    logic [SW-1:0]   ssel [N];
    logic            sext [N];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] x);
        return {x[14:0], x[15] ^ x[14] ^ x[12] ^ x[3]};
    endfunction

    // Reference product: element s of each channel, AND or XNOR by mode
    function automatic logic [NO-1:0] model_bits(input int m, input logic [L-1:0] d,
                                                 input logic [NO*L-1:0] w, input int s);
        logic [NO-1:0] r;
        for (int c = 0; c < NO; c++) begin
            r[c] = (m == 1) ? (d[s] == w[c*L + s]) : (d[s] & w[c*L + s]);
        end
        return r;
    endfunction

    // Monitor: pop on every valid, flag anything unexpected or missing
    always @(negedge clk) begin
        if (mon_en) begin
            for (int m = 0; m < 2; m++) begin
                check($sformatf("excl%0d", m), {63'd0, bv[m] & cv[m]}, 64'd0);
                if (bv[m]) begin
                    if (qb[m].size() == 0) fail_now($sformatf("bit%0d unexpected", m));
                    else check($sformatf("bits%0d", m), {62'd0, rb[m]}, {62'd0, qb[m].pop_front()});
                end else if (qb[m].size() != 0) begin
                    fail_now($sformatf("bit%0d missing", m));
                    void'(qb[m].pop_front());
                end
                if (cv[m]) begin
                    if (qc[m].size() == 0) fail_now($sformatf("count%0d unexpected", m));
                    else begin
                        cnt_exp_t e;
                        e = qc[m].pop_front();
                        check($sformatf("count%0d", m), {54'd0, cnt[m]}, {54'd0, e.cnt});
                        check($sformatf("count_cycle%0d", m), cyc, e.cyc);
                    end
                end else if (qc[m].size() != 0) begin
                    fail_now($sformatf("count%0d missing", m));
                    void'(qc[m].pop_front());
                end
            end
        end
    end

    task automatic jitter_inputs();
        data     = L'($urandom);
        weights  = (NO*L)'($urandom);
        sel      = SW'($urandom);
        sel_ext  = 1'($urandom_range(0, 1));
        in_valid = 1'($urandom_range(0, 1));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        jitter_inputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
        lfsr_m = SEED;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            start = 1'b0;
            jitter_inputs();
            @(posedge clk);
            #1;
            check("busy_idle", {62'd0, busy[1], busy[0]}, 64'd0);
        end
    endtask

    task automatic rand_tables();
        for (int k = 0; k < N; k++) begin
            sd[k]   = L'($urandom);
            swt[k]  = (NO*L)'($urandom);
            ssel[k] = SW'($urandom);
            sext[k] = 1'($urandom_range(0, 1));
        end
    endtask

    // stall: 0 none, 1 alternate (invalid first), 2 random. abort_after >= 0 resets mid-window.
    task automatic run_window(input int stall, input int abort_after);
        int k, ncyc, c0, s;
        int acc [2][NO];
        logic [NO-1:0] eb [2];
        bit v;
        cnt_exp_t e;
        k = 0;
        ncyc = 0;
        for (int m = 0; m < 2; m++) for (int c = 0; c < NO; c++) acc[m][c] = 0;
        jitter_inputs();
        start = 1'b1;
        @(posedge clk);
        #1;
        c0 = cyc;
        while (k < N) begin
            check("busy_run", {62'd0, busy[1], busy[0]}, 64'd3);
            if (k == abort_after) begin
                rst = 1'b1;
                in_valid = 1'b0;
                start = 1'b0;
                @(posedge clk);
                #1;
                rst = 1'b0;
                lfsr_m = SEED;
                check("busy_abort", {62'd0, busy[1], busy[0]}, 64'd0);
                check("count_abort", {44'd0, cnt[1], cnt[0]}, 64'd0);
                return;
            end
            case (stall)
                0:       v = 1'b1;
                1:       v = (ncyc % 2) == 1;
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            start = 1'($urandom_range(0, 1));
            if (v) begin
                data = sd[k];
                weights = swt[k];
                sel = ssel[k];
                sel_ext = sext[k];
                s = sext[k] ? int'(ssel[k]) : int'({lfsr_m[4], lfsr_m[1]});
                for (int m = 0; m < 2; m++) begin
                    eb[m] = model_bits(m, sd[k], swt[k], s);
                    for (int c = 0; c < NO; c++) acc[m][c] += int'(eb[m][c]);
                end
                lfsr_m = lfsr_next(lfsr_m);
                k++;
            end else begin
                jitter_inputs();
                in_valid = 1'b0;
            end
            in_valid = v;
            ncyc++;
            @(posedge clk);
            if (v) for (int m = 0; m < 2; m++) qb[m].push_back(eb[m]);
            #1;
        end
        // DONE cycle: inputs ignored
        check("busy_done", {62'd0, busy[1], busy[0]}, 64'd3);
        jitter_inputs();
        start = 1'($urandom_range(0, 1));
        @(posedge clk);
        for (int m = 0; m < 2; m++) begin
            e.cyc = c0 + ncyc + 1;
            e.cnt = '0;
            for (int c = 0; c < NO; c++) e.cnt[c*CW +: CW] = CW'(acc[m][c]);
            qc[m].push_back(e);
        end
        #1;
        start = 1'b0;
        in_valid = 1'b0;
        check("busy_post", {62'd0, busy[1], busy[0]}, 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held 8 cycles with random inputs
        repeat (8) begin
            jitter_inputs();
            start = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            for (int m = 0; m < 2; m++)
                check($sformatf("reset%0d", m),
                      {50'd0, busy[m], rb[m], bv[m], cnt[m], cv[m]}, 64'd0);
        end
        rst = 1'b0;
        start = 1'b0;
        lfsr_m = SEED;
        mon_en = 1'b1;
        idle(2);

        // All-ones data, channel0 weights ones, channel1 zeros
        for (int k = 0; k < N; k++) begin
            sd[k] = 4'b1111; swt[k] = 8'h0F; ssel[k] = '0; sext[k] = 1'b0;
        end
        run_window(0, -1);
        idle(2);

        // External select cycling through elements, data 0101, weights ones
        for (int k = 0; k < N; k++) begin
            sd[k] = 4'b0101; swt[k] = 8'hFF; ssel[k] = SW'(k); sext[k] = 1'b1;
        end
        run_window(0, -1);
        idle(1);

        // Zero data against zero then all-one weights
        for (int k = 0; k < N; k++) begin
            sd[k] = 4'b0000; swt[k] = 8'h00; ssel[k] = SW'($urandom); sext[k] = 1'b0;
        end
        run_window(0, -1);
        for (int k = 0; k < N; k++) swt[k] = 8'hFF;
        run_window(0, -1);

        // Same sample stream with and without stalls from the same seed
        rand_tables();
        do_reset();
        run_window(0, -1);
        do_reset();
        run_window(1, -1);
        idle(2);

        // Reset after 5 samples, then a complete fresh window
        rand_tables();
        run_window(0, 5);
        idle(3);
        run_window(0, -1);

        // Random windows with random stalls and select source
        repeat (3) begin
            rand_tables();
            run_window(2, -1);
            idle($urandom_range(0, 3));
        end

        idle(4);
        for (int m = 0; m < 2; m++) begin
            check($sformatf("drain_bits%0d", m), qb[m].size(), 0);
            check($sformatf("drain_cnt%0d", m), qc[m].size(), 0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
